clk_div_multi: RTL

Parametrised multi-channel integer clock divider for the multi-clock system. It derives NUM_CH independent divided clocks from one reference clock, each with its own ratio and enable. New ratios are staged and applied only at a period boundary, so no channel ever produces a runt pulse. Each channel also drops out of divide mode only at a period boundary. It replaces single-channel dividers wherever the design needs more than one derived clock, such as UART TX/RX clocks.

---
 rtl/clk_div_multi.sv | 109 ++++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider; ratio changes and disables take effect only at period boundaries.
// Define CLK_DIV_TICK_EN to drive o_tick; otherwise o_tick is tied low and its registers are removed.
module clk_div_multi #(
   parameter int unsigned RATIO_WD = 8,
   parameter int unsigned NUM_CH   = 2
) (
   input  logic                       i_ref_clk,
   input  logic                       i_rst,
   input  logic [NUM_CH-1:0]          i_clk_en,
   input  logic [NUM_CH*RATIO_WD-1:0] i_div_ratio,
   input  logic [NUM_CH-1:0]          i_ratio_load,
   output logic [NUM_CH-1:0]          o_div_clk,
   output logic [NUM_CH-1:0]          o_ratio_ack,
   output logic [NUM_CH-1:0]          o_tick
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [RATIO_WD-1:0] ONE = RATIO_WD'(1);
   localparam logic [RATIO_WD-1:0] TWO = RATIO_WD'(2);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      state_t              state, state_nx;
      logic [RATIO_WD-1:0] act_ratio, act_nx;
      logic [RATIO_WD-1:0] pend_ratio;
      logic [RATIO_WD-1:0] count, count_nx;
      logic                pend_vld;
      logic                div_r, div_nx;
      logic                ack;
      logic                boundary, apply;

      // Validity is judged on the ratio in force after this edge, so a ratio applied
      // in IDLE can start the channel at once and an invalid one can never enter RUN.
      always_comb begin
         boundary = (state != IDLE) && (count == act_ratio - ONE);
         apply    = pend_vld && ((state == IDLE) || boundary);
         act_nx   = apply ? pend_ratio : act_ratio;
         state_nx = state;
         count_nx = '0;
         div_nx   = 1'b0;
         case (state)
            IDLE: begin
               if (i_clk_en[k] && (act_nx >= TWO)) begin
                  state_nx = RUN;
                  div_nx   = 1'b1;
               end
            end
            default: begin
               if (boundary && (!i_clk_en[k] || (act_nx < TWO))) begin
                  state_nx = IDLE;
               end else begin
                  state_nx = i_clk_en[k] ? RUN : DRAIN;
                  count_nx = boundary ? '0 : count + ONE;
                  div_nx   = count_nx < (act_nx >> 1);
               end
            end
         endcase
      end

      always_ff @(posedge i_ref_clk or posedge i_rst) begin
         if (i_rst) begin
            state      <= IDLE;
            act_ratio  <= '0;
            pend_ratio <= '0;
            pend_vld   <= 1'b0;
            count      <= '0;
            div_r      <= 1'b0;
            ack        <= 1'b0;
         end else begin
            state     <= state_nx;
            act_ratio <= act_nx;
            count     <= count_nx;
            div_r     <= div_nx;
            ack       <= apply;
            // A load coinciding with an apply re-arms pending for the next boundary.
            if (i_ratio_load[k]) begin
               pend_ratio <= i_div_ratio[k*RATIO_WD +: RATIO_WD];
               pend_vld   <= 1'b1;
            end else if (apply) begin
               pend_vld <= 1'b0;
            end
         end
      end

      assign o_div_clk[k]   = (state == IDLE) ? i_ref_clk : div_r;
      assign o_ratio_ack[k] = ack;

`ifdef CLK_DIV_TICK_EN
      logic tick;

      always_ff @(posedge i_ref_clk or posedge i_rst) begin
         if (i_rst) begin
            tick <= 1'b0;
         end else begin
            tick <= (state_nx != IDLE) && (count_nx == '0);
         end
      end

      assign o_tick[k] = tick;
`else
      assign o_tick[k] = 1'b0;
`endif
   end

endmodule
